// File: rtl/cpu.sv
// Accumulator CPU: 8-phase instruction cycle over a unified 32x8 memory (instance mem1).
// Define CPU_DBG_PORTS_EN to expose dbg_acc, dbg_ir and dbg_phase.

module cpu_mem #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned AWIDTH = 5
) (
  input  logic              clock,
  input  logic              we,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] wdata,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] memory [0:(2**AWIDTH)-1];

  assign rdata = memory[addr];

  always_ff @(posedge clock) begin
    if (we) memory[addr] <= wdata;
  end

endmodule

module cpu #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned AWIDTH = 5
) (
  input  logic              clock,
  input  logic              reset_req,
  output logic              halt,
  output logic [AWIDTH-1:0] pc_addr,
  output logic [2:0]        opcode
`ifdef CPU_DBG_PORTS_EN
  ,
  output logic [DWIDTH-1:0] dbg_acc,
  output logic [DWIDTH-1:0] dbg_ir,
  output logic [2:0]        dbg_phase
`endif
);

  if (DWIDTH != AWIDTH + 3) begin : g_width_check
    $error("cpu: DWIDTH must equal AWIDTH+3");
  end

  typedef enum logic [2:0] {
    INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE
  } phase_t;

  typedef enum logic [2:0] {
    OP_HLT, OP_SKZ, OP_ADD, OP_AND, OP_XOR, OP_LDA, OP_STO, OP_JMP
  } op_t;

  phase_t            phase, phase_next;
  logic [AWIDTH-1:0] pc, pc_next;
  logic [DWIDTH-1:0] acc, acc_next;
  logic [DWIDTH-1:0] ir, ir_next;
  logic              halt_q, halt_next;
  logic              mem_we;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_rdata;
  logic [AWIDTH-1:0] ir_addr;
  op_t               op;

  assign ir_addr = ir[AWIDTH-1:0];
  assign op      = op_t'(ir[DWIDTH-1:AWIDTH]);
  // Instruction half of the cycle addresses via PC, operand half via IR.
  assign mem_addr = (phase < OP_ADDR) ? pc : ir_addr;

  cpu_mem #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) mem1 (
    .clock (clock),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (acc),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clock or posedge reset_req) begin
    if (reset_req) begin
      phase  <= INST_ADDR;
      pc     <= '0;
      acc    <= '0;
      ir     <= '0;
      halt_q <= 1'b0;
    end else begin
      phase  <= phase_next;
      pc     <= pc_next;
      acc    <= acc_next;
      ir     <= ir_next;
      halt_q <= halt_next;
    end
  end

  always_comb begin
    phase_next = phase;
    pc_next    = pc;
    acc_next   = acc;
    ir_next    = ir;
    halt_next  = halt_q;
    mem_we     = 1'b0;
    if (!halt_q) begin
      unique case (phase)
        INST_ADDR:  phase_next = INST_FETCH;
        INST_FETCH: phase_next = INST_LOAD;
        INST_LOAD: begin
          phase_next = IDLE;
          ir_next    = mem_rdata;
        end
        IDLE:       phase_next = OP_ADDR;
        OP_ADDR: begin
          phase_next = OP_FETCH;
          if (op == OP_HLT) halt_next = 1'b1;
          else              pc_next   = pc + AWIDTH'(1);
        end
        OP_FETCH:   phase_next = ALU_OP;
        ALU_OP: begin
          phase_next = STORE;
          if (op == OP_SKZ && acc == '0) pc_next = pc + AWIDTH'(1);
          if (op == OP_JMP)              pc_next = ir_addr;
        end
        STORE: begin
          phase_next = INST_ADDR;
          unique case (op)
            OP_ADD:  acc_next = acc + mem_rdata;
            OP_AND:  acc_next = acc & mem_rdata;
            OP_XOR:  acc_next = acc ^ mem_rdata;
            OP_LDA:  acc_next = mem_rdata;
            OP_STO:  mem_we   = 1'b1;
            default: acc_next = acc;
          endcase
        end
        default:    phase_next = INST_ADDR;
      endcase
    end
  end

  assign halt    = halt_q;
  assign pc_addr = pc;
  assign opcode  = ir[DWIDTH-1:AWIDTH];

`ifdef CPU_DBG_PORTS_EN
  assign dbg_acc   = acc;
  assign dbg_ir    = ir;
  assign dbg_phase = phase;
`endif

endmodule

// File: tb/tb_cpu.sv
// Scoreboard bench for cpu: programs are poked into mem1, expected results queued up
// front and compared once the CPU halts; stores to 0x1B are checked as they happen.

module tb_cpu;

  logic       clock = 1'b0;
  logic       reset_req = 1'b1;
  logic       halt;
  logic [4:0] pc_addr;
  logic [2:0] opcode;

  cpu #(.DWIDTH(8), .AWIDTH(5)) dut (
    .clock     (clock),
    .reset_req (reset_req),
    .halt      (halt),
    .pc_addr   (pc_addr),
    .opcode    (opcode)
  );

  always #5 clock = ~clock;

  localparam int unsigned K_PC = 0, K_MEM = 1, K_CYC = 2;

  typedef struct {
    string       tag;
    int unsigned kind;
    logic [4:0]  addr;
    logic [31:0] value;
  } exp_t;

  exp_t        sb_q[$];
  logic [7:0]  fib_q[$];
  bit          fib_on = 1'b0;
  int unsigned fib_writes = 0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cycles;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input int unsigned kind, input logic [4:0] addr,
                         input logic [31:0] value);
    exp_t e;
    e.tag = tag; e.kind = kind; e.addr = addr; e.value = value;
    sb_q.push_back(e);
  endtask

  task automatic poke(input logic [4:0] a, input logic [7:0] v);
    dut.mem1.memory[a] <= v;
  endtask

  task automatic begin_test();
    @(negedge clock);
    reset_req = 1'b1;
    for (int i = 0; i < 32; i++) dut.mem1.memory[i] <= 8'h00;
    #1;
  endtask

  task automatic release_reset();
    #1;
    @(negedge clock);
    reset_req = 1'b0;
  endtask

  task automatic run_to_halt(input int unsigned budget, output int unsigned n);
    n = 0;
    while (!halt && n < budget) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (!halt) check("halt_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain_sb(input int unsigned n);
    exp_t        e;
    logic [31:0] got;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.kind)
        K_PC:    got = 32'(pc_addr);
        K_MEM:   got = 32'(dut.mem1.memory[e.addr]);
        default: got = n;
      endcase
      check(e.tag, got, e.value);
    end
  endtask

  // Each STO to 0x1B writes the accumulator on the edge ending phase 7.
  always @(negedge clock) begin
    if (fib_on && dut.mem_we && dut.mem_addr == 5'h1B) begin
      fib_writes++;
      if (fib_q.size() > 0) check($sformatf("fib_%0d", fib_writes), 32'(dut.acc), 32'(fib_q.pop_front()));
    end
  end

  task automatic load_add_store(input logic [7:0] pre1d);
    poke(5'h00, 8'hBE); poke(5'h01, 8'h5F); poke(5'h02, 8'hDD); poke(5'h03, 8'h00);
    poke(5'h1E, 8'h05); poke(5'h1F, 8'h07); poke(5'h1D, pre1d);
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_pc", 32'(pc_addr), 32'd0);
    check("rst_halt", 32'(halt), 32'd0);
    check("rst_opcode", 32'(opcode), 32'd0);

    // Load / add / store
    begin_test();
    load_add_store(8'h00);
    sb_push("las_mem1d", K_MEM, 5'h1D, 32'h0C);
    sb_push("las_pc", K_PC, 5'h00, 32'h03);
    sb_push("las_cycles", K_CYC, 5'h00, 32'd29);
    release_reset();
    run_to_halt(200, cycles);
    drain_sb(cycles);

    // Wrap-around add, AND, XOR
    begin_test();
    poke(5'h00, 8'hBE); poke(5'h01, 8'h5F); poke(5'h02, 8'hDD);
    poke(5'h03, 8'hBC); poke(5'h04, 8'h7B); poke(5'h05, 8'hDA);
    poke(5'h06, 8'h99); poke(5'h07, 8'hD8); poke(5'h08, 8'h00);
    poke(5'h1E, 8'hFF); poke(5'h1F, 8'h02); poke(5'h1C, 8'h3C);
    poke(5'h1B, 8'h0F); poke(5'h19, 8'hFF);
    sb_push("wrap_add", K_MEM, 5'h1D, 32'h01);
    sb_push("and_res", K_MEM, 5'h1A, 32'h0C);
    sb_push("xor_res", K_MEM, 5'h18, 32'hF3);
    sb_push("logic_pc", K_PC, 5'h00, 32'h08);
    release_reset();
    run_to_halt(300, cycles);
    drain_sb(cycles);

    // SKZ taken and not taken
    for (int s = 0; s < 2; s++) begin
      begin_test();
      poke(5'h00, 8'hBE); poke(5'h01, 8'h20); poke(5'h1E, 8'(s));
      sb_push($sformatf("skz_pc_acc%0d", s), K_PC, 5'h00, (s == 0) ? 32'h03 : 32'h02);
      release_reset();
      run_to_halt(200, cycles);
      drain_sb(cycles);
    end

    // JMP over unexecuted code, then frozen after halt
    begin_test();
    poke(5'h00, 8'hF0);
    for (int a = 1; a < 16; a++) poke(5'(a), 8'hBF);
    poke(5'h10, 8'h00);
    sb_push("jmp_pc", K_PC, 5'h00, 32'h10);
    sb_push("jmp_cycles", K_CYC, 5'h00, 32'd13);
    release_reset();
    run_to_halt(100, cycles);
    drain_sb(cycles);
    repeat (3) @(posedge clock);
    #1;
    check("jmp_pc_at16", 32'(pc_addr), 32'h10);
    check("jmp_halt_at16", 32'(halt), 32'd1);

    // Self-modifying: STO overwrites the JMP at address 2 with HLT
    begin_test();
    poke(5'h00, 8'hBE); poke(5'h01, 8'hC2); poke(5'h02, 8'hF0); poke(5'h03, 8'h00);
    poke(5'h10, 8'h00); poke(5'h1E, 8'h00);
    sb_push("selfmod_pc", K_PC, 5'h00, 32'h02);
    release_reset();
    run_to_halt(200, cycles);
    drain_sb(cycles);

    // Reset mid phase 5 of the STO aborts it, then the program reruns
    begin_test();
    load_add_store(8'h55);
    release_reset();
    repeat (21) @(posedge clock);
    #3;
    reset_req = 1'b1;
    #1;
    check("midrst_pc", 32'(pc_addr), 32'd0);
    check("midrst_halt", 32'(halt), 32'd0);
    check("midrst_opcode", 32'(opcode), 32'd0);
    repeat (3) @(posedge clock);
    #1;
    check("midrst_nowrite", 32'(dut.mem1.memory[29]), 32'h55);
    sb_push("rerun_mem1d", K_MEM, 5'h1D, 32'h0C);
    sb_push("rerun_pc", K_PC, 5'h00, 32'h03);
    sb_push("rerun_cycles", K_CYC, 5'h00, 32'd29);
    release_reset();
    run_to_halt(200, cycles);
    drain_sb(cycles);

    // Fibonacci: a at 1C, b at 1D, temp at 1E, stop value 0x90 at 1A
    begin_test();
    poke(5'h00, 8'hBC); poke(5'h01, 8'hDB); poke(5'h02, 8'h9A); poke(5'h03, 8'h20);
    poke(5'h04, 8'hE6); poke(5'h05, 8'h00); poke(5'h06, 8'hBC); poke(5'h07, 8'h5D);
    poke(5'h08, 8'hDE); poke(5'h09, 8'hBD); poke(5'h0A, 8'hDC); poke(5'h0B, 8'hBE);
    poke(5'h0C, 8'hDD); poke(5'h0D, 8'hE0);
    poke(5'h1A, 8'h90); poke(5'h1C, 8'h00); poke(5'h1D, 8'h01);
    begin
      logic [7:0] fa, fb, ft;
      fa = 8'd0; fb = 8'd1;
      for (int k = 0; k < 13; k++) begin
        fib_q.push_back(fa);
        ft = fa + fb; fa = fb; fb = ft;
      end
    end
    sb_push("fib_pc", K_PC, 5'h00, 32'h05);
    fib_writes = 0;
    fib_on = 1'b1;
    release_reset();
    run_to_halt(3000, cycles);
    drain_sb(cycles);
    fib_on = 1'b0;
    check("fib_write_count", fib_writes, 32'd13);
    check("fib_queue_left", 32'(fib_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
